// File: rtl/mod_apb_master.sv
// APB requester: takes single read/write commands on a valid/ready port and runs the
// APB SETUP/ACCESS sequence. It returns one response per command and aborts stalled transfers.
module mod_apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit TO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              accept_s;

  // A pending response blocks new commands unless it is being popped this cycle.
  assign cmd_ready = (state_q == ST_IDLE) && (!rsp_valid_q || rsp_ready);
  assign accept_s  = cmd_valid && cmd_ready;

  // Next-state, APB outputs and response capture.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wait_cnt_d  = wait_cnt_q;
    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d   = ST_SETUP;
          addr_d    = cmd_addr;
          pwdata_d  = cmd_wdata;
          pwrite_d  = cmd_write;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end else begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d    = ST_ACCESS;
        wait_cnt_d = {CNT_W{1'b0}};
        psel_d     = 1'b1;
        penable_d  = 1'b1;
      end
      ST_ACCESS: begin
        // pready wins over a timeout landing on the same cycle.
        if (pready) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? {DATA_W{1'b0}} : prdata;
        end else if (TO_EN && (wait_cnt_q == CNT_LIMIT)) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = {DATA_W{1'b0}};
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1'b1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      pwdata_q    <= {DATA_W{1'b0}};
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign addr      = addr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mod_apb_master.sv
// Directed self-checking bench for mod_apb_master (TIMEOUT=4) with hand-computed expectations.
module tb_mod_apb_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [7:0] addr;
  logic [7:0] pwdata;
  logic       pwrite;
  logic       psel;
  logic       penable;
  logic [7:0] prdata;
  logic       pready = 1'b0;
  logic       busy;

  logic       slave_mode = 1'b0;
  logic [7:0] prdata_drv = 8'h00;

  int checks = 0;
  int errors = 0;

  // In slave mode read data is derived from the address the master presents.
  assign prdata = slave_mode ? (addr ^ 8'hA5) : prdata_drv;

  always #5 clk = ~clk;

  mod_apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr(addr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] b2b_addr [4];
  int         acc_cyc [4];
  int         k;
  int         r;
  logic       acc;

  initial begin
    b2b_addr[0] = 8'h40; b2b_addr[1] = 8'h41; b2b_addr[2] = 8'h42; b2b_addr[3] = 8'h43;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_addr", addr, 8'h00);
    check("rst_pwdata", pwdata, 8'h00);
    check("rst_pwrite", pwrite, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);

    // Write 0x3C to 0x05, zero wait states
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h05; cmd_wdata = 8'h3C;
    pready = 1'b1; rsp_ready = 1'b1;
    #1;
    check("wr_cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    check("wr_setup_psel", psel, 1'b1);
    check("wr_setup_penable", penable, 1'b0);
    check("wr_addr", addr, 8'h05);
    check("wr_pwdata", pwdata, 8'h3C);
    check("wr_pwrite", pwrite, 1'b1);
    check("wr_busy", busy, 1'b1);
    check("wr_setup_cmd_ready", cmd_ready, 1'b0);
    tick();
    check("wr_access_psel", psel, 1'b1);
    check("wr_access_penable", penable, 1'b1);
    tick();
    check("wr_rsp_valid", rsp_valid, 1'b1);
    check("wr_rsp_err", rsp_err, 1'b0);
    check("wr_rsp_rdata", rsp_rdata, 8'h00);
    check("wr_done_psel", psel, 1'b0);
    check("wr_done_busy", busy, 1'b0);
    tick();
    check("wr_rsp_popped", rsp_valid, 1'b0);

    // Read 0x12 with two wait states; prdata only valid on the completion cycle
    pready = 1'b0; prdata_drv = 8'hFF;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h12; cmd_wdata = 8'hEE;
    tick();
    cmd_valid = 1'b0;
    check("rd_setup_penable", penable, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rd_access%0d_penable", i), penable, 1'b1);
    end
    pready = 1'b1; prdata_drv = 8'h5A;
    tick();
    pready = 1'b0; prdata_drv = 8'hFF;
    check("rd_done_penable", penable, 1'b0);
    check("rd_rsp_valid", rsp_valid, 1'b1);
    check("rd_rsp_rdata", rsp_rdata, 8'h5A);
    check("rd_rsp_err", rsp_err, 1'b0);
    check("rd_addr_hold", addr, 8'h12);
    tick();

    // Timeout: pready stuck low
    prdata_drv = 8'h77;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h2B;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("to_access%0d_penable", i), penable, 1'b1);
    end
    tick();
    check("to_psel", psel, 1'b0);
    check("to_penable", penable, 1'b0);
    check("to_rsp_valid", rsp_valid, 1'b1);
    check("to_rsp_err", rsp_err, 1'b1);
    check("to_rsp_rdata", rsp_rdata, 8'h00);
    tick();

    // Response backpressure, then pop and accept in the same cycle
    rsp_ready = 1'b0; pready = 1'b1; prdata_drv = 8'hA5;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h21;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    prdata_drv = 8'h00;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30; cmd_wdata = 8'h99;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_cmd_ready", i), cmd_ready, 1'b0);
      check($sformatf("bp%0d_rsp_valid", i), rsp_valid, 1'b1);
      check($sformatf("bp%0d_rsp_rdata", i), rsp_rdata, 8'hA5);
      check($sformatf("bp%0d_rsp_err", i), rsp_err, 1'b0);
      check($sformatf("bp%0d_psel", i), psel, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    check("bp_popped", rsp_valid, 1'b0);
    check("bp_new_psel", psel, 1'b1);
    check("bp_new_penable", penable, 1'b0);
    check("bp_new_addr", addr, 8'h30);
    check("bp_new_pwrite", pwrite, 1'b1);
    tick();
    tick();
    check("bp_new_rsp_valid", rsp_valid, 1'b1);
    tick();

    // Reset asserted during ACCESS
    pready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h55;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("mid_penable_before", penable, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_psel", psel, 1'b0);
    check("mid_penable", penable, 1'b0);
    check("mid_rsp_valid", rsp_valid, 1'b0);
    check("mid_busy", busy, 1'b0);
    pready = 1'b1;
    tick(); tick();
    check("mid_no_rsp", rsp_valid, 1'b0);

    // Back-to-back reads with cmd_valid held high
    slave_mode = 1'b1; pready = 1'b1; rsp_ready = 1'b1;
    k = 0; r = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = b2b_addr[0];
    #1;
    for (int c = 0; c < 40 && r < 4; c++) begin
      acc = cmd_valid && cmd_ready;
      if (rsp_valid) begin
        check($sformatf("b2b_rdata%0d", r), rsp_rdata, b2b_addr[r] ^ 8'hA5);
        check($sformatf("b2b_err%0d", r), rsp_err, 1'b0);
        r++;
      end
      if (acc) acc_cyc[k] = c;
      tick();
      if (acc) begin
        k++;
        if (k < 4) cmd_addr = b2b_addr[k];
        else cmd_valid = 1'b0;
        #1;
      end
    end
    check("b2b_rsp_count", r, 4);
    check("b2b_accept_count", k, 4);
    if (k == 4) begin
      for (int i = 1; i < 4; i++)
        check($sformatf("b2b_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
